// File: rtl/instruction_encoder.sv
// MIPS R/I/J field-set encoder with a one-word registered output stage,
// sequential byte addressing from BASE_ADDR and a word budget of DEPTH.
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               opcode,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              immediate,
  input  logic [25:0]              address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_addr,
  output logic [1:0]               out_format,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  typedef enum logic [1:0] {EMPTY, LOADED, DONE} state_t;

  state_t          state_q, state_d;
  logic            valid_d;
  logic [31:0]     instr_d, addr_d;
  logic [1:0]      fmt_d;
  logic [CW-1:0]   count_d;
  logic            accept;
  logic [31:0]     enc_word;
  logic [1:0]      enc_fmt;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !reset && !full && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Field packing by opcode class
  always_comb begin
    enc_fmt  = FMT_I;
    enc_word = {opcode, rs, rt, immediate};
    if (opcode == 6'b000000) begin
      enc_fmt  = FMT_R;
      enc_word = {opcode, rs, rt, rd, shamt, funct};
    end else if (opcode == 6'b000010 || opcode == 6'b000011) begin
      enc_fmt  = FMT_J;
      enc_word = {opcode, address};
    end
  end

  // Next-state and output-stage update
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    instr_d = out_instruction;
    addr_d  = out_addr;
    fmt_d   = out_format;
    count_d = count;
    if (clear) begin
      state_d = EMPTY;
      valid_d = 1'b0;
      count_d = '0;
    end else begin
      if (out_valid && out_ready) valid_d = 1'b0;
      if (accept) begin
        valid_d = 1'b1;
        instr_d = enc_word;
        fmt_d   = enc_fmt;
        addr_d  = BASE_ADDR + (32'(count) << 2);
        count_d = CW'(count + 1'b1);
      end
      case (state_q)
        EMPTY:   if (accept) state_d = LOADED;
        LOADED:  if (!valid_d) state_d = EMPTY;
        DONE:    state_d = DONE;
        default: state_d = EMPTY;
      endcase
      // Accepting the last budgeted word locks out further input
      if (accept && count == CW'(DEPTH - 1)) state_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= EMPTY;
      out_valid       <= 1'b0;
      out_instruction <= 32'h0;
      out_addr        <= BASE_ADDR;
      out_format      <= FMT_R;
      count           <= '0;
    end else begin
      state_q         <= state_d;
      out_valid       <= valid_d;
      out_instruction <= instr_d;
      out_addr        <= addr_d;
      out_format      <= fmt_d;
      count           <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench: encodings, backpressure, clear, reset and DEPTH=4 fill.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0, clear4 = 1'b0;
  logic        in_valid = 1'b0, in_valid4 = 1'b0;
  logic        out_ready = 1'b0, out_ready4 = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] immediate = '0;
  logic [25:0] address = '0;

  logic        in_ready, out_valid, full;
  logic [31:0] out_instruction, out_addr;
  logic [1:0]  out_format;
  logic [10:0] count;
  logic        in_ready4, out_valid4, full4;
  logic [31:0] out_instruction4, out_addr4;
  logic [1:0]  out_format4;
  logic [2:0]  count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.BASE_ADDR(32'h0), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_addr(out_addr), .out_format(out_format),
    .count(count), .full(full));

  instruction_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear4), .in_valid(in_valid4), .in_ready(in_ready4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_instruction(out_instruction4), .out_addr(out_addr4), .out_format(out_format4),
    .count(count4), .full(full4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add();
    opcode = 6'h00; rs = 5'd9; rt = 5'd10; rd = 5'd8; shamt = 5'd0; funct = 6'h20;
    immediate = 16'hFFFF; address = 26'h3FFFFFF;
  endtask

  task automatic set_addi();
    opcode = 6'h08; rs = 5'd9; rt = 5'd8; rd = 5'h1F; shamt = 5'h1F; funct = 6'h3F;
    immediate = 16'h0005; address = 26'h0;
  endtask

  task automatic set_jump(input logic [5:0] op);
    opcode = op; rs = 5'h1F; rt = 5'h1F; rd = 5'h1F; shamt = 5'h1F; funct = 6'h3F;
    immediate = 16'hFFFF; address = 26'h0100000;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (out_instruction !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", out_instruction); end
    tests++; if (out_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", out_addr); end
    tests++; if (out_format !== 2'b00) begin fails++; $display("FAIL reset_format got %b want 00", out_format); end
    tests++; if (count !== 11'd0 || full !== 1'b0) begin fails++; $display("FAIL reset_count got %0d/%b want 0/0", count, full); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_add();
    set_add(); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_in_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b want 1", out_valid); end
    tests++; if (out_instruction !== 32'h012A4020) begin fails++; $display("FAIL add_word got %h want 012a4020", out_instruction); end
    tests++; if (out_format !== 2'b00 || out_addr !== 32'h0) begin fails++; $display("FAIL add_fmt_addr got %b/%h want 00/0", out_format, out_addr); end
    tests++; if (count !== 11'd1) begin fails++; $display("FAIL add_count got %0d want 1", count); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain got %b want 0", out_valid); end
  endtask

  task automatic test_addi();
    set_addi(); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_instruction !== 32'h21280005) begin fails++; $display("FAIL addi_word got %h want 21280005", out_instruction); end
    tests++; if (out_format !== 2'b01 || out_addr !== 32'h4) begin fails++; $display("FAIL addi_fmt_addr got %b/%h want 01/4", out_format, out_addr); end
    step();
  endtask

  task automatic test_back_to_back();
    set_jump(6'h02); in_valid = 1'b1; out_ready = 1'b1;
    step();
    tests++; if (out_instruction !== 32'h08100000 || out_format !== 2'b10) begin fails++; $display("FAIL j_word got %h/%b want 08100000/10", out_instruction, out_format); end
    tests++; if (out_addr !== 32'h8) begin fails++; $display("FAIL j_addr got %h want 8", out_addr); end
    set_jump(6'h03);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (out_instruction !== 32'h0C100000 || out_format !== 2'b10) begin fails++; $display("FAIL jal_word got %h/%b want 0c100000/10", out_instruction, out_format); end
    tests++; if (out_addr !== 32'hC || count !== 11'd4) begin fails++; $display("FAIL jal_addr_count got %h/%0d want c/4", out_addr, count); end
    step();
  endtask

  task automatic test_backpressure();
    set_add(); in_valid = 1'b1; out_ready = 1'b0;
    step();
    set_addi();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      tests++;
      if (out_valid !== 1'b1 || out_instruction !== 32'h012A4020 || out_addr !== 32'h10 || count !== 11'd5) begin
        fails++; $display("FAIL bp_hold[%0d] got %b/%h/%h/%0d want 1/012a4020/10/5", i, out_valid, out_instruction, out_addr, count);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++;
    if (out_instruction !== 32'h21280005 || out_addr !== 32'h14 || count !== 11'd6) begin
      fails++; $display("FAIL bp_second got %h/%h/%0d want 21280005/14/6", out_instruction, out_addr, count);
    end
    step();
  endtask

  task automatic test_clear();
    set_add(); in_valid = 1'b1; out_ready = 1'b0;
    step();
    clear = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL clear_in_ready got %b want 0", in_ready); end
    step();
    clear = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || count !== 11'd0 || full !== 1'b0) begin fails++; $display("FAIL clear_state got %b/%0d/%b want 0/0/0", out_valid, count, full); end
    set_addi(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_addr !== 32'h0 || out_instruction !== 32'h21280005 || count !== 11'd1) begin fails++; $display("FAIL clear_next got %h/%h/%0d want 0/21280005/1", out_addr, out_instruction, count); end
    step();
  endtask

  task automatic test_reset_mid();
    set_jump(6'h02); in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_loaded got %b want 1", out_valid); end
    #1 reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || count !== 11'd0) begin fails++; $display("FAIL rmid_async got %b/%0d want 0/0", out_valid, count); end
    @(negedge clk);
    reset = 1'b0;
    set_add(); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_addr !== 32'h0 || out_instruction !== 32'h012A4020) begin fails++; $display("FAIL rmid_next got %h/%h want 0/012a4020", out_addr, out_instruction); end
    step();
  endtask

  task automatic test_full();
    set_addi(); in_valid4 = 1'b1; out_ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (in_ready4 !== (i < 4)) begin fails++; $display("FAIL full_in_ready[%0d] got %b want %b", i, in_ready4, (i < 4)); end
      step();
      if (i < 4) begin
        tests++; if (out_valid4 !== 1'b1 || out_addr4 !== 32'(4 * i)) begin fails++; $display("FAIL full_addr[%0d] got %b/%h want 1/%h", i, out_valid4, out_addr4, 4 * i); end
        tests++; if (full4 !== (i == 3)) begin fails++; $display("FAIL full_flag[%0d] got %b want %b", i, full4, (i == 3)); end
      end
    end
    in_valid4 = 1'b0;
    tests++; if (out_valid4 !== 1'b0 || count4 !== 3'd4 || full4 !== 1'b1) begin fails++; $display("FAIL full_fifth got %b/%0d/%b want 0/4/1", out_valid4, count4, full4); end
    clear4 = 1'b1;
    step();
    clear4 = 1'b0;
    tests++; if (count4 !== 3'd0 || full4 !== 1'b0) begin fails++; $display("FAIL full_clear got %0d/%b want 0/0", count4, full4); end
    set_add(); in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    tests++; if (out_addr4 !== 32'h0 || out_instruction4 !== 32'h012A4020) begin fails++; $display("FAIL full_restart got %h/%h want 0/012a4020", out_addr4, out_instruction4); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
